// File: rtl/rng_health_sampler.sv
// rng_health_sampler
//   Consumer side of the 32-bit ring-oscillator RNG. Enables the generator,
//   samples its word every SAMPLE_GAP cycles, throws away a warm-up burst of
//   WARMUP_WORDS samples, then runs a repetition-count test (RCT) and an
//   adaptive-proportion test (APT) on every sample. Passing words are offered
//   downstream on a valid/ready handshake; a failing word halts the generator
//   and latches a sticky alarm flag.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      pulse: begin warm-up from IDLE or FAIL, clears fail flags
//   stop       pulse: return to IDLE from any state (wins over start)
//   rng_word   32-bit word from the generator
//   rng_enable generator enable, high in WARMUP/SAMPLE/HOLD
//   out_word   health-tested word
//   out_valid  out_word is valid
//   out_ready  downstream accepts out_word
//   busy       state is neither IDLE nor FAIL
//   rct_fail   sticky repetition-count failure
//   apt_fail   sticky adaptive-proportion failure
module rng_health_sampler #(
  parameter int WARMUP_WORDS = 16,
  parameter int SAMPLE_GAP   = 4,
  parameter int RCT_CUTOFF   = 3,
  parameter int APT_WINDOW   = 64,
  parameter int APT_CUTOFF   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] rng_word,
  output logic        rng_enable,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        rct_fail,
  output logic        apt_fail
);

  localparam int GAP_W  = $clog2(SAMPLE_GAP);
  localparam int WARM_W = $clog2(WARMUP_WORDS + 1);
  localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
  localparam int WIN_W  = $clog2(APT_WINDOW + 1);

  localparam logic [GAP_W-1:0]  GAP_ZERO  = GAP_W'(0);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [WARM_W-1:0] WARM_ZERO = WARM_W'(0);
  localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_WORDS - 1);
  localparam logic [RCT_W-1:0]  RCT_ZERO  = RCT_W'(0);
  localparam logic [RCT_W-1:0]  RCT_ONE   = RCT_W'(1);
  localparam logic [RCT_W-1:0]  RCT_MAX   = RCT_W'(RCT_CUTOFF);
  localparam logic [WIN_W-1:0]  WIN_ZERO  = WIN_W'(0);
  localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(APT_WINDOW);
  localparam logic [WIN_W-1:0]  APT_MAX   = WIN_W'(APT_CUTOFF);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t            state_r;
  logic [GAP_W-1:0]  gap_r;
  logic [WARM_W-1:0] warm_r;
  logic [RCT_W-1:0]  rct_cnt_r;
  logic [31:0]       prev_r;
  logic [31:0]       apt_ref_r;
  logic [WIN_W-1:0]  apt_cnt_r;
  logic [WIN_W-1:0]  win_cnt_r;
  logic [31:0]       out_word_r;
  logic              out_valid_r;
  logic              active_r;
  logic              rct_fail_r;
  logic              apt_fail_r;

  logic              sample_tick_s;
  logic              new_win_s;
  logic [RCT_W-1:0]  rct_cnt_next_s;
  logic [WIN_W-1:0]  apt_cnt_next_s;
  logic [WIN_W-1:0]  win_cnt_next_s;
  logic              rct_hit_s;
  logic              apt_hit_s;

  // Health-test arithmetic for the word currently on rng_word; only consumed on a SAMPLE tick.
  always_comb begin
    sample_tick_s = (gap_r == GAP_LAST);
    // rct_cnt_r == 0 marks the first tested sample after warm-up.
    if (rct_cnt_r == RCT_ZERO) begin
      rct_cnt_next_s = RCT_ONE;
    end else if (rng_word == prev_r) begin
      if (rct_cnt_r == RCT_MAX) begin
        rct_cnt_next_s = RCT_MAX;
      end else begin
        rct_cnt_next_s = rct_cnt_r + RCT_ONE;
      end
    end else begin
      rct_cnt_next_s = RCT_ONE;
    end
    // A window opens on the very first tested sample and after a full window.
    new_win_s = (win_cnt_r == WIN_ZERO) || (win_cnt_r == WIN_LAST);
    if (new_win_s) begin
      win_cnt_next_s = WIN_ONE;
      apt_cnt_next_s = WIN_ONE;
    end else begin
      win_cnt_next_s = win_cnt_r + WIN_ONE;
      if (rng_word == apt_ref_r) begin
        apt_cnt_next_s = apt_cnt_r + WIN_ONE;
      end else begin
        apt_cnt_next_s = apt_cnt_r;
      end
    end
    rct_hit_s = (rct_cnt_next_s >= RCT_MAX);
    apt_hit_s = (apt_cnt_next_s >= APT_MAX);
  end

  // Main controller: state, gap/warm-up counters, test state, output register and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      gap_r       <= GAP_ZERO;
      warm_r      <= WARM_ZERO;
      rct_cnt_r   <= RCT_ZERO;
      prev_r      <= 32'd0;
      apt_ref_r   <= 32'd0;
      apt_cnt_r   <= WIN_ZERO;
      win_cnt_r   <= WIN_ZERO;
      out_word_r  <= 32'd0;
      out_valid_r <= 1'b0;
      active_r    <= 1'b0;
      rct_fail_r  <= 1'b0;
      apt_fail_r  <= 1'b0;
    end else if (stop) begin
      // Stop wins over start and over a same-cycle handshake; flags are kept.
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      active_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FAIL: begin
          out_valid_r <= 1'b0;
          if (start) begin
            state_r    <= ST_WARMUP;
            active_r   <= 1'b1;
            gap_r      <= GAP_ZERO;
            warm_r     <= WARM_ZERO;
            rct_cnt_r  <= RCT_ZERO;
            apt_cnt_r  <= WIN_ZERO;
            win_cnt_r  <= WIN_ZERO;
            prev_r     <= 32'd0;
            apt_ref_r  <= 32'd0;
            rct_fail_r <= 1'b0;
            apt_fail_r <= 1'b0;
          end
        end
        ST_WARMUP: begin
          if (sample_tick_s) begin
            gap_r <= GAP_ZERO;
            if (warm_r == WARM_LAST) begin
              warm_r  <= WARM_ZERO;
              state_r <= ST_SAMPLE;
            end else begin
              warm_r <= warm_r + WARM_ONE;
            end
          end else begin
            gap_r <= gap_r + GAP_ONE;
          end
        end
        ST_SAMPLE: begin
          if (sample_tick_s) begin
            gap_r <= GAP_ZERO;
            if (rct_hit_s || apt_hit_s) begin
              state_r    <= ST_FAIL;
              active_r   <= 1'b0;
              rct_fail_r <= rct_fail_r | rct_hit_s;
              apt_fail_r <= apt_fail_r | apt_hit_s;
            end else begin
              rct_cnt_r   <= rct_cnt_next_s;
              prev_r      <= rng_word;
              apt_cnt_r   <= apt_cnt_next_s;
              win_cnt_r   <= win_cnt_next_s;
              apt_ref_r   <= new_win_s ? rng_word : apt_ref_r;
              out_word_r  <= rng_word;
              out_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
            end
          end else begin
            gap_r <= gap_r + GAP_ONE;
          end
        end
        ST_HOLD: begin
          // Gap counter and test state stay frozen until the word is taken.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            gap_r       <= GAP_ZERO;
            state_r     <= ST_SAMPLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          active_r    <= 1'b0;
        end
      endcase
    end
  end

  assign rng_enable = active_r;
  assign busy       = active_r;
  assign out_word   = out_word_r;
  assign out_valid  = out_valid_r;
  assign rct_fail   = rct_fail_r;
  assign apt_fail   = apt_fail_r;

endmodule

// File: tb/tb_rng_health_sampler.sv
// Testbench for rng_health_sampler: directed scenarios with a scoreboard.
// The stimulus process pushes expected accepted words into exp_q; a monitor
// pops and compares them on every handshake and checks out_word stability
// under backpressure.
module tb_rng_health_sampler;

  localparam int GEN_CONST = 0;
  localparam int GEN_INC   = 1;
  localparam int GEN_SEQ   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] rng_word;
  logic        rng_enable;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        rct_fail;
  logic        apt_fail;

  int          checks = 0;
  int          failures = 0;
  int          hs_count = 0;
  int          cyc = 0;
  int          gen_mode = GEN_CONST;
  int          seq_base = 0;
  logic [31:0] const_word = 32'd0;
  logic [31:0] exp_q[$];

  rng_health_sampler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .rng_word   (rng_word),
    .rng_enable (rng_enable),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .rct_fail   (rct_fail),
    .apt_fail   (apt_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seq_word(input int idx);
    if (idx % 2 == 0) return 32'hA5A5_A5A5;
    else return 32'h0000_1000 + 32'(idx);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_flag(input bit want_apt, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((want_apt && apt_fail) || (!want_apt && rct_fail)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_hs(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (hs_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Generator model: cycle counter plus the word the RNG presents (changes 2 units after posedge).
  initial begin
    rng_word = 32'd0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #2;
      case (gen_mode)
        GEN_INC: rng_word = 32'(cyc);
        GEN_SEQ: rng_word = seq_word(hs_count - seq_base);
        default: rng_word = const_word;
      endcase
    end
  end

  // Monitor: compares every accepted word with the scoreboard and checks hold stability.
  initial begin
    logic [31:0] held_word;
    logic [31:0] exp_w;
    bit          held;
    held = 1'b0;
    held_word = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (held) check("hold_stable", out_word, held_word);
        if (out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got 0x%08h expected none", out_word);
          end else begin
            exp_w = exp_q.pop_front();
            check("accepted_word", out_word, exp_w);
          end
          hs_count++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_word = out_word;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    int base;
    int t0;
    int a_edge;
    bit ok;
    bit seen_valid;

    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_enable", {31'd0, rng_enable}, 32'd0);
    check("rst_word", out_word, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_flags", {30'd0, rct_fail, apt_fail}, 32'd0);

    // Latency and streaming with an incrementing generator.
    gen_mode = GEN_INC;
    base = hs_count;
    step();
    start = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(t0 + 67 + 5 * k));
    step();
    start = 1'b0;
    check("start_enable", {31'd0, rng_enable}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    wait_valid(150, ok);
    check("first_valid_seen", {31'd0, ok}, 32'd1);
    check("first_valid_latency", 32'(cyc - t0), 32'd68);
    wait_hs(base + 5, 200, ok);
    check("stream_handshakes", {31'd0, ok}, 32'd1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check("stop_idle", {29'd0, busy, rng_enable, out_valid}, 32'd0);
    check("stream_flags", {30'd0, rct_fail, apt_fail}, 32'd0);

    // Repetition-count failure on a stuck word.
    gen_mode = GEN_CONST;
    const_word = 32'hDEAD_BEEF;
    base = hs_count;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_flag(1'b0, 200, ok);
    check("rct_fail_seen", {31'd0, ok}, 32'd1);
    check("rct_apt_clear", {31'd0, apt_fail}, 32'd0);
    check("rct_halt", {30'd0, busy, rng_enable}, 32'd0);
    check("rct_handshakes", 32'(hs_count - base), 32'd2);
    seen_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("rct_no_valid", {31'd0, seen_valid}, 32'd0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("rct_cleared", {31'd0, rct_fail}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Adaptive-proportion failure: reference word on every other sample.
    gen_mode = GEN_SEQ;
    seq_base = hs_count;
    base = hs_count;
    for (int k = 0; k < 14; k++) exp_q.push_back(seq_word(k));
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_flag(1'b1, 300, ok);
    check("apt_fail_seen", {31'd0, ok}, 32'd1);
    check("apt_rct_clear", {31'd0, rct_fail}, 32'd0);
    check("apt_handshakes", 32'(hs_count - base), 32'd14);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_keeps_apt", {31'd0, apt_fail}, 32'd1);
    check("stop_fail_idle", {31'd0, busy}, 32'd0);

    // Backpressure: word held for 20 cycles, next sample 4 cycles after acceptance.
    gen_mode = GEN_INC;
    out_ready = 1'b0;
    step();
    start = 1'b1;
    t0 = cyc + 1;
    exp_q.push_back(32'(t0 + 67));
    step();
    start = 1'b0;
    check("start_clears_apt", {31'd0, apt_fail}, 32'd0);
    wait_valid(150, ok);
    check("bp_valid_seen", {31'd0, ok}, 32'd1);
    repeat (20) @(negedge clk);
    check("bp_still_valid", {31'd0, out_valid}, 32'd1);
    check("bp_word", out_word, 32'(t0 + 67));
    step();
    out_ready = 1'b1;
    step();
    a_edge = cyc;
    out_ready = 1'b0;
    wait_valid(20, ok);
    check("bp_next_seen", {31'd0, ok}, 32'd1);
    check("bp_next_latency", 32'(cyc - a_edge), 32'd4);
    check("bp_next_word", out_word, 32'(a_edge + 3));
    exp_q.push_back(32'(a_edge + 3));

    // Stop and start together during HOLD, with a same-cycle handshake.
    step();
    stop = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    check("stop_start_idle", {29'd0, busy, rng_enable, out_valid}, 32'd0);
    step();
    start = 1'b1;
    t0 = cyc + 1;
    step();
    start = 1'b0;
    wait_valid(150, ok);
    check("rewarm_valid_seen", {31'd0, ok}, 32'd1);
    check("rewarm_latency", 32'(cyc - t0), 32'd68);
    check("rewarm_word", out_word, 32'(t0 + 67));

    // Asynchronous reset in the middle of HOLD.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {27'd0, out_valid, rng_enable, busy, rct_fail, apt_fail}, 32'd0);
    check("async_rst_word", out_word, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {29'd0, busy, rng_enable, out_valid}, 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
